// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: shared UART definitions (receiver FSM states, default bit period).
// Used by uart_rx and the companion transmitter.
package uart_pkg;
  // 100 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 868;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_sync.sv
`timescale 1ns/1ps
// uart_sync: two-flop synchronizer for the asynchronous serial line.
// clk: system clock; reset: async active-low, flops reset to 1 (line idle);
// d: asynchronous input; q: synchronized output (2-cycle latency).
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= 2'b11;
    else sync_q <= sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver with one-byte holding register.
// clk: system clock; reset: async active-low; din: serial line (idle high);
// dout: last received byte; vdout: unread byte present; rd: consume pulse;
// overrun: sticky, byte overwritten before rd; frame_err: one-cycle pulse on
// low stop bit; busy: receiver not idle.
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] dout,
  output logic       vdout,
  input  logic       rd,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic din_s;
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dout_q, dout_d;
  logic vdout_q, vdout_d, overrun_q, overrun_d, frame_err_q, frame_err_d, busy_q, busy_d;
  logic stop_hit, deliver, ack;
  uart_sync u_sync (.clk(clk), .reset(reset), .d(din), .q(din_s));
  // Start is confirmed at half a bit, so every later full-bit count lands
  // mid-bit; leaving STOP mid-stop-bit lets a back-to-back start be seen.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!din_s) state_d = START;
      end
      START:
        if (cnt_q == HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = din_s ? IDLE : DATA;
        end
      DATA:
        if (cnt_q == FULL) begin
          cnt_d = '0;
          shift_d = {din_s, shift_q[7:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      STOP:
        if (cnt_q == FULL) begin
          cnt_d = '0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  // A read in the delivery cycle consumes the old byte, so it never counts
  // toward overrun.
  always_comb begin
    stop_hit = (state_q == STOP) && (cnt_q == FULL);
    deliver = stop_hit && din_s;
    ack = rd && vdout_q;
    dout_d = deliver ? shift_q : dout_q;
    vdout_d = deliver || (vdout_q && !rd);
    overrun_d = ack ? 1'b0 : (overrun_q || (deliver && vdout_q));
    frame_err_d = stop_hit && !din_s;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dout_q <= '0;
      vdout_q <= 1'b0;
      overrun_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vdout_q <= vdout_d;
      overrun_q <= overrun_d;
      frame_err_q <= frame_err_d;
      busy_q <= busy_d;
    end
  assign dout = dout_q;
  assign vdout = vdout_q;
  assign overrun = overrun_q;
  assign frame_err = frame_err_q;
  assign busy = busy_q;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per bit (100 MHz / 115200 baud).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port din  input  1  serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port dout  output  8  last received byte.
REQ-006 SHALL have port vdout  output  1  level, high while dout holds an unread byte.
REQ-007 SHALL have port rd  input  1  consumer acknowledge, one-cycle pulse, clears vdout.
REQ-008 SHALL have port overrun  output  1  sticky, byte lost before rd.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 SHALL pass din through a 2-flop synchronizer; all FSM decisions use the synchronized value (2-cycle latency).
REQ-012 SHALL implement states IDLE, START, DATA, STOP with a bit-period counter and 3-bit bit index.
REQ-013 IDLE: synchronized din = 0 -> START, counter cleared; otherwise remain.
REQ-014 START: at counter = CLKS_PER_BIT/2 - 1 sample line; 0 -> DATA with counter and bit index cleared; 1 -> IDLE (glitch rejected, no outputs change).
REQ-015 DATA: at counter = CLKS_PER_BIT - 1 sample line into shift register LSB first, clear counter, increment index; after index 7 sampled -> STOP.
REQ-016 STOP: at counter = CLKS_PER_BIT - 1 sample line; 1 -> deliver byte; 0 -> frame_err pulse, byte discarded, vdout/dout unchanged; both -> IDLE.
REQ-017 Delivery SHALL load dout and set vdout on the clock edge following the stop sample.
REQ-018 rd with vdout = 1 SHALL clear vdout next cycle and clear overrun; rd with vdout = 0 SHALL be ignored.
REQ-019 Delivery while vdout = 1 and rd = 0 SHALL overwrite dout, keep vdout = 1, set overrun.
REQ-020 Delivery and rd in the same cycle SHALL load the new byte, keep vdout = 1, leave overrun unchanged by the old byte.
REQ-021 After STOP the FSM SHALL be back in IDLE mid-stop-bit so a back-to-back start edge is detected.
REQ-022 Counter width SHALL be $clog2(CLKS_PER_BIT); counter never exceeds CLKS_PER_BIT - 1.

Reset
REQ-023 reset = 0 SHALL asynchronously force: state IDLE, counter 0, index 0, shift 0, synchronizer flops 1, dout 0, vdout 0, overrun 0, frame_err 0, busy 0.
REQ-024 reset asserted mid-frame SHALL abandon the frame with no delivery and no frame_err; after release the next falling edge starts a new frame.

Structure
REQ-025 State encoding and default CLKS_PER_BIT SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-026 The 2-flop synchronizer SHALL be sub-module uart_sync (async active-low reset, reset value 1).
REQ-027 Implementation SHALL be synthesizable, no latches, one always block per register group.

Verification (CLKS_PER_BIT = 16 unless stated)
REQ-028 Frame 0xA5 with valid stop -> dout = 0xA5, vdout = 1 on edge after stop sample, frame_err = 0, overrun = 0.
REQ-029 Frame 0x3C with stop bit 0 -> frame_err pulses one cycle, vdout stays 0, dout stays 0x00.
REQ-030 Two back-to-back frames 0x11, 0x22 without rd -> dout = 0x22, vdout = 1, overrun = 1; rd -> vdout = 0, overrun = 0.
REQ-031 din low for 4 cycles then high -> FSM returns IDLE, no vdout, no frame_err.
REQ-032 reset pulsed low during DATA bit 4 of frame 0xFF -> all outputs 0, next frame 0x5A received correctly.
REQ-033 Default CLKS_PER_BIT = 868, frame 0x55 at 115200 baud with +/-2% bit-time skew -> dout = 0x55, no errors.
